neuron_packet_loader: RTL and testbench
=======================================

// Module: neuron_packet_loader
// PURPOSE
//  Upstream feeder for one neuron's config port. Accepts whole config packets (1..MAX_BYTES
//  bytes) from the host/bus side, buffers them in a small packet FIFO, and serialises them
//  byte by byte onto the neuron's data[7:0] / load_data strobe with fixed setup and gap timing.
//  Content-agnostic: header bytes (8'hFF weight, 8'hFE param, 8'hFD mode) come from the sender.
// PARAMETERS
//  MAX_BYTES   10  max bytes per packet; pkt_data width = 8*MAX_BYTES
//  LEN_W       4   width of pkt_len; must hold MAX_BYTES
//  GAP_CYCLES  3   idle cycles after each load_data pulse (byte period = 2+GAP_CYCLES)
//  FIFO_DEPTH  4   packets buffered (power of 2)
// PORTS
//  clk        in   1            clock, rising edge
//  rst        in   1            asynchronous, active-low reset
//  pkt_valid  in   1            packet offered
//  pkt_ready  out  1            loader can accept; transfer on pkt_valid & pkt_ready
//  pkt_data   in   8*MAX_BYTES  byte0 (first sent) in [7:0], byte k in [8k+7:8k]
//  pkt_len    in   LEN_W        number of valid bytes, legal 1..MAX_BYTES
//  flush      in   1            synchronous abort and FIFO clear
//  data_out   out  8            byte to neuron data input
//  load_data  out  1            one-cycle strobe; data_out stable across it
//  busy       out  1            FSM not IDLE or FIFO not empty
//  err_len    out  1            one-cycle pulse: illegal pkt_len offered and dropped
// BEHAVIOUR
//  Reset (rst=0, async): data_out=0, load_data=0, err_len=0, busy=0, FIFO empty, FSM IDLE;
//   pkt_ready=1 from first edge after release. Mid-packet reset discards everything, no flush pulse.
//  Accept: pkt_ready = !fifo_full (no bypass on full even if popping same cycle).
//   pkt_len==0 or >MAX_BYTES: handshake completes, packet not stored, err_len=1 next cycle.
//  FSM: IDLE -> SETUP -> PULSE -> GAP -> (SETUP next byte | SETUP byte0 of next packet | IDLE).
//   IDLE: if FIFO non-empty, pop head into working reg, idx=0, go SETUP.
//   SETUP (1 cyc): data_out <= byte[idx].  PULSE (1 cyc): load_data=1.
//   GAP (GAP_CYCLES cyc, counter): load_data=0, data_out held; at end idx++; if idx==len then
//   pop next packet directly into SETUP when FIFO non-empty, else IDLE.
//  Latency (idle, FIFO empty): packet accepted at edge E -> data_out=byte0 after edge E+2,
//   load_data high in cycle after edge E+3. Consecutive strobes exactly 2+GAP_CYCLES apart,
//   including across packet boundaries.
//  data_out holds last byte sent while IDLE (never returns to 0 except on reset).
//  flush: at next edge FIFO emptied, FSM->IDLE, load_data=0, data_out held; a packet offered
//   in the flush cycle is dropped (pkt_ready=0 while flush=1). flush has priority over accept/pop.
//  busy drops in the cycle after the final GAP cycle of the last queued packet.
// STRUCTURE
//  Package neuron_loader_pkg: FSM state enum (IDLE,SETUP,PULSE,GAP), header constants
//   HDR_WEIGHT=8'hFF, HDR_PARAM=8'hFE, HDR_MODE=8'hFD (for benches/drivers).
//  Sub-module packet_fifo: sync FIFO, width 8*MAX_BYTES+LEN_W, depth FIFO_DEPTH, full/empty,
//   sync clear; rest (FSM, byte mux, gap counter, len check) in this module.
// TESTING
//  1 rst low mid-run -> data_out=0, load_data=0, busy=0, err_len=0; pkt_ready=1 after release.
//  2 10-byte weight pkt FF,38,01,01,00,03,04,05,00,00 -> 10 strobes 5 cycles apart, data_out
//    matches each byte at strobe, first strobe 4 edges after accept, busy low after last gap.
//  3 weight pkt then mode pkt FD,01,00,00 queued -> 14 strobes, uniform 5-cycle spacing, order kept.
//  4 offer 6 pkts of len 2 while busy -> pkt_ready low after 4 buffered + 1 in flight; all 6
//    eventually sent, none lost or duplicated.
//  5 pkt_len=0 and pkt_len=11 -> err_len one-cycle pulse each, no strobe, busy unchanged.
//  6 flush after 3rd strobe of 10-byte pkt with 2 queued -> no further strobes, busy=0 next
//    cycle, data_out=3rd byte; subsequent pkt sent normally.

Source files
------------

// File: rtl/neuron_loader_pkg.sv
// Shared definitions for the neuron packet loader: FSM state encodings, config header bytes
// and the packet length legality rule.
package neuron_loader_pkg;

    typedef logic [1:0] loader_state_t;

    localparam loader_state_t StIdle  = 2'd0;
    localparam loader_state_t StSetup = 2'd1;
    localparam loader_state_t StPulse = 2'd2;
    localparam loader_state_t StGap   = 2'd3;

    // First byte of each config packet, chosen by the sender.
    localparam logic [7:0] HDR_WEIGHT = 8'hFF;
    localparam logic [7:0] HDR_PARAM  = 8'hFE;
    localparam logic [7:0] HDR_MODE   = 8'hFD;

    function automatic logic len_legal(input int unsigned len, input int unsigned max_bytes);
        return (len != 0) && (len <= max_bytes);
    endfunction

endpackage

// File: rtl/packet_fifo.sv
// Synchronous packet FIFO with full/empty flags and a synchronous clear that wins over
// push and pop. DEPTH must be a power of two, at least 2.
module packet_fifo
    import neuron_loader_pkg::*;
#(
    parameter int unsigned WIDTH = 84,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int unsigned PtrW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PtrW:0]    wr_ptr_q;
    logic [PtrW:0]    rd_ptr_q;
    logic             do_push;
    logic             do_pop;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[PtrW] != rd_ptr_q[PtrW]) &&
                   (wr_ptr_q[PtrW-1:0] == rd_ptr_q[PtrW-1:0]);

    assign do_push = push & ~full & ~clear;
    assign do_pop  = pop & ~empty & ~clear;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else if (clear) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + (PtrW + 1)'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + (PtrW + 1)'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q[PtrW-1:0]] <= wdata;
        end
    end

    assign rdata = mem_q[rd_ptr_q[PtrW-1:0]];

endmodule

// File: rtl/neuron_packet_loader.sv
// Buffers whole config packets and serialises them byte by byte onto a neuron's data/load_data
// port with a fixed setup cycle, one strobe cycle and GAP_CYCLES idle cycles per byte.
module neuron_packet_loader
    import neuron_loader_pkg::*;
#(
    parameter int unsigned MAX_BYTES  = 10,
    parameter int unsigned LEN_W      = 4,
    parameter int unsigned GAP_CYCLES = 3,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   pkt_valid,
    output logic                   pkt_ready,
    input  logic [8*MAX_BYTES-1:0] pkt_data,
    input  logic [LEN_W-1:0]       pkt_len,
    input  logic                   flush,
    output logic [7:0]             data_out,
    output logic                   load_data,
    output logic                   busy,
    output logic                   err_len
);

    localparam int unsigned DataW  = 8 * MAX_BYTES;
    localparam int unsigned EntryW = DataW + LEN_W;
    localparam int unsigned GapW   = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GapW-1:0] GapLast = GapW'(GAP_CYCLES - 1);

    logic              ready_en_q;
    logic              accept;
    logic              len_ok;
    logic              fifo_full;
    logic              fifo_empty;
    logic              fifo_pop;
    logic [EntryW-1:0] fifo_rdata;
    logic [DataW-1:0]  head_data;
    logic [LEN_W-1:0]  head_len;

    loader_state_t     state_q, state_d;
    logic [DataW-1:0]  cur_data_q, cur_data_d;
    logic [LEN_W-1:0]  cur_len_q, cur_len_d;
    logic [LEN_W-1:0]  idx_q, idx_d;
    logic [LEN_W-1:0]  idx_next;
    logic [GapW-1:0]   gap_q, gap_d;
    logic [7:0]        data_q, data_d;
    logic              load_q, load_d;
    logic              err_q;
    logic              take_head;
    logic [7:0]        cur_byte;

    // Ready is held low until the first edge after reset release and while flushing.
    assign pkt_ready = ready_en_q & ~fifo_full & ~flush;
    assign accept    = pkt_valid & pkt_ready;
    assign len_ok    = len_legal(32'(pkt_len), MAX_BYTES);

    packet_fifo #(
        .WIDTH (EntryW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .clear (flush),
        .push  (accept & len_ok),
        .wdata ({pkt_len, pkt_data}),
        .pop   (fifo_pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign head_len  = fifo_rdata[EntryW-1 -: LEN_W];
    assign head_data = fifo_rdata[DataW-1:0];
    assign idx_next  = idx_q + LEN_W'(1);

    always_comb begin
        cur_byte = '0;
        for (int k = 0; k < MAX_BYTES; k++) begin
            if (idx_q == LEN_W'(k)) begin
                cur_byte = cur_data_q[8*k +: 8];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        cur_data_d = cur_data_q;
        cur_len_d  = cur_len_q;
        idx_d      = idx_q;
        gap_d      = gap_q;
        data_d     = data_q;
        load_d     = 1'b0;
        take_head  = 1'b0;
        fifo_pop   = 1'b0;

        if (flush) begin
            state_d = StIdle;
            gap_d   = '0;
        end else begin
            case (state_q)
                StIdle: begin
                    take_head = ~fifo_empty;
                end
                StSetup: begin
                    data_d  = cur_byte;
                    state_d = StPulse;
                end
                StPulse: begin
                    load_d  = 1'b1;
                    gap_d   = '0;
                    state_d = StGap;
                end
                StGap: begin
                    if (gap_q == GapLast) begin
                        gap_d = '0;
                        if (idx_next == cur_len_q) begin
                            // Chain straight into the next packet so strobe spacing stays uniform.
                            take_head = ~fifo_empty;
                            state_d   = StIdle;
                        end else begin
                            idx_d   = idx_next;
                            state_d = StSetup;
                        end
                    end else begin
                        gap_d = gap_q + GapW'(1);
                    end
                end
                default: state_d = StIdle;
            endcase

            if (take_head) begin
                fifo_pop   = 1'b1;
                cur_data_d = head_data;
                cur_len_d  = head_len;
                idx_d      = '0;
                state_d    = StSetup;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ready_en_q <= 1'b0;
            state_q    <= StIdle;
            cur_data_q <= '0;
            cur_len_q  <= '0;
            idx_q      <= '0;
            gap_q      <= '0;
            data_q     <= '0;
            load_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            ready_en_q <= 1'b1;
            state_q    <= state_d;
            cur_data_q <= cur_data_d;
            cur_len_q  <= cur_len_d;
            idx_q      <= idx_d;
            gap_q      <= gap_d;
            data_q     <= data_d;
            load_q     <= load_d;
            err_q      <= accept & ~len_ok;
        end
    end

    assign data_out  = data_q;
    assign load_data = load_q;
    assign err_len   = err_q;
    assign busy      = (state_q != StIdle) | ~fifo_empty;

endmodule

// File: tb/tb_neuron_packet_loader.sv
// Scoreboard bench for neuron_packet_loader: accepted packets queue their bytes, and a
// negedge monitor checks every load_data strobe against the queue head and the strobe spacing.
module tb_neuron_packet_loader;
    import neuron_loader_pkg::*;

    localparam int unsigned MAX_BYTES  = 10;
    localparam int unsigned LEN_W      = 4;
    localparam int unsigned GAP_CYCLES = 3;
    localparam int unsigned FIFO_DEPTH = 4;
    localparam int unsigned PERIOD     = 2 + GAP_CYCLES;

    logic                   clk = 1'b0;
    logic                   rst = 1'b0;
    logic                   pkt_valid = 1'b0;
    logic                   pkt_ready;
    logic [8*MAX_BYTES-1:0] pkt_data = '0;
    logic [LEN_W-1:0]       pkt_len = '0;
    logic                   flush = 1'b0;
    logic [7:0]             data_out;
    logic                   load_data;
    logic                   busy;
    logic                   err_len;

    neuron_packet_loader #(
        .MAX_BYTES  (MAX_BYTES),
        .LEN_W      (LEN_W),
        .GAP_CYCLES (GAP_CYCLES),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .pkt_valid (pkt_valid),
        .pkt_ready (pkt_ready),
        .pkt_data  (pkt_data),
        .pkt_len   (pkt_len),
        .flush     (flush),
        .data_out  (data_out),
        .load_data (load_data),
        .busy      (busy),
        .err_len   (err_len)
    );

    always #5 clk = ~clk;

    int         n_cmp = 0;
    int         n_bad = 0;
    logic [7:0] exp_q[$];
    int         strobe_cnt = 0;
    int         cyc = 0;
    int         last_strobe_cyc = 0;
    bit         have_last = 1'b0;
    logic       prev_load = 1'b0;
    logic [7:0] exp_byte;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Monitor: every strobe must carry the next expected byte, PERIOD cycles after the last.
    initial forever begin
        @(negedge clk);
        if (load_data) begin
            strobe_cnt++;
            check("strobe width", prev_load, 1'b0);
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected strobe: got data_out 0x%0h, expected no strobe at %0t",
                         data_out, $time);
            end else begin
                exp_byte = exp_q.pop_front();
                check("strobe byte", data_out, exp_byte);
            end
            if (have_last) begin
                check("strobe spacing", cyc - last_strobe_cyc, PERIOD);
            end
            have_last = 1'b1;
            last_strobe_cyc = cyc;
        end
        if (!busy) have_last = 1'b0;
        prev_load = load_data;
    end

    task automatic send(input logic [8*MAX_BYTES-1:0] data, input int len);
        bit acc = 1'b0;
        @(negedge clk);
        pkt_data  = data;
        pkt_len   = LEN_W'(len);
        pkt_valid = 1'b1;
        for (int t = 0; t < 300 && !acc; t++) begin
            #1;
            if (pkt_ready) acc = 1'b1;
            else @(negedge clk);
        end
        check("accept within bound", acc, 1'b1);
        if (acc) begin
            if (len >= 1 && len <= MAX_BYTES) begin
                for (int k = 0; k < len; k++) exp_q.push_back(data[8*k +: 8]);
            end
            @(posedge clk);
            #1;
        end
        pkt_valid = 1'b0;
    endtask

    task automatic wait_strobes(input int target, input string name);
        int t = 0;
        while (strobe_cnt < target && t < 500) begin
            @(posedge clk);
            #2;
            t++;
        end
        check(name, strobe_cnt >= target, 1'b1);
    endtask

    task automatic wait_drain(input string name);
        int t = 0;
        while ((exp_q.size() != 0 || busy) && t < 1000) begin
            @(negedge clk);
            t++;
        end
        check({name, " bytes left"}, exp_q.size(), 0);
        check({name, " busy"}, busy, 1'b0);
    endtask

    logic [79:0] w_pkt;
    logic [79:0] m_pkt;
    logic [79:0] a_pkt;
    int          base;

    initial begin
        w_pkt = {8'h00, 8'h00, 8'h05, 8'h04, 8'h03, 8'h00, 8'h01, 8'h01, 8'h38, HDR_WEIGHT};
        m_pkt = {48'h0, 8'h00, 8'h00, 8'h01, HDR_MODE};
        a_pkt = 80'hA9_A8_A7_A6_A5_A4_A3_A2_A1_A0;

        // Power-on reset
        repeat (2) @(negedge clk);
        check("rst data_out", data_out, 8'h00);
        check("rst load_data", load_data, 1'b0);
        check("rst busy", busy, 1'b0);
        check("rst err_len", err_len, 1'b0);
        check("rst pkt_ready", pkt_ready, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        check("ready after release", pkt_ready, 1'b1);

        // 10-byte weight packet: latency, bytes, busy fall
        base = strobe_cnt;
        send(w_pkt, 10);
        @(negedge clk);
        check("lat E+0 load", load_data, 1'b0);
        check("lat E+0 busy", busy, 1'b1);
        @(negedge clk);
        @(negedge clk);
        check("lat E+2 data_out", data_out, 8'hFF);
        check("lat E+2 load", load_data, 1'b0);
        @(negedge clk);
        check("lat E+3 load", load_data, 1'b1);
        wait_strobes(base + 10, "weight 10 strobes");
        @(negedge clk);
        check("gap2 busy", busy, 1'b1);
        @(negedge clk);
        check("gap3 busy", busy, 1'b1);
        @(negedge clk);
        check("after last gap busy", busy, 1'b0);
        check("weight strobe count", strobe_cnt - base, 10);
        wait_drain("weight");

        // Weight then mode packet back to back
        base = strobe_cnt;
        send(w_pkt, 10);
        send(m_pkt, 4);
        wait_drain("weight+mode");
        check("weight+mode strobe count", strobe_cnt - base, 14);

        // Six 2-byte packets offered while busy
        base = strobe_cnt;
        for (int i = 1; i <= 5; i++) begin
            send({64'h0, 8'(16 * i + 2), 8'(16 * i + 1)}, 2);
        end
        @(negedge clk);
        check("ready low when full", pkt_ready, 1'b0);
        check("busy when full", busy, 1'b1);
        send({64'h0, 8'h62, 8'h61}, 2);
        wait_drain("six pkts");
        check("six pkts strobe count", strobe_cnt - base, 12);

        // Illegal lengths
        base = strobe_cnt;
        send(w_pkt, 0);
        @(negedge clk);
        check("len0 err pulse", err_len, 1'b1);
        check("len0 busy", busy, 1'b0);
        @(negedge clk);
        check("len0 err clears", err_len, 1'b0);
        send(w_pkt, 11);
        @(negedge clk);
        check("len11 err pulse", err_len, 1'b1);
        check("len11 busy", busy, 1'b0);
        @(negedge clk);
        check("len11 err clears", err_len, 1'b0);
        check("len11 busy after", busy, 1'b0);
        repeat (8) @(negedge clk);
        check("bad len no strobes", strobe_cnt - base, 0);

        // Flush after third strobe with two packets queued
        base = strobe_cnt;
        send(a_pkt, 10);
        send({64'h0, 8'hB2, 8'hB1}, 2);
        send({64'h0, 8'hC2, 8'hC1}, 2);
        wait_strobes(base + 3, "flush third strobe");
        flush     = 1'b1;
        pkt_data  = {64'h0, 8'hD2, 8'hD1};
        pkt_len   = LEN_W'(2);
        pkt_valid = 1'b1;
        #1;
        check("ready low in flush", pkt_ready, 1'b0);
        exp_q.delete();
        @(posedge clk);
        #1;
        flush     = 1'b0;
        pkt_valid = 1'b0;
        @(negedge clk);
        check("flush busy", busy, 1'b0);
        check("flush load_data", load_data, 1'b0);
        check("flush data_out held", data_out, 8'hA2);
        repeat (15) @(negedge clk);
        check("flush no more strobes", strobe_cnt - base, 3);
        check("flushed pkt not stored", busy, 1'b0);
        send({64'h0, 8'hD2, 8'hD1}, 2);
        wait_drain("after flush");

        // Reset in the middle of a packet
        base = strobe_cnt;
        send(80'h63_62_61_60_5F_5E_5D_5C_5B_5A, 10);
        wait_strobes(base + 2, "mid reset strobes");
        rst = 1'b0;
        #1;
        check("mid rst data_out", data_out, 8'h00);
        check("mid rst load_data", load_data, 1'b0);
        check("mid rst busy", busy, 1'b0);
        check("mid rst err_len", err_len, 1'b0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("mid rst ready after release", pkt_ready, 1'b1);
        check("mid rst busy after release", busy, 1'b0);
        repeat (10) @(negedge clk);
        check("mid rst no residue", strobe_cnt - base, 2);
        send(m_pkt, 4);
        wait_drain("after mid reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
